pwm: RTL and testbench

PWM -- requirements
Module: pwm

---
 rtl/pwm.sv | 65 ++++++
 tb/tb_pwm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pwm.sv
// PWM generator: free-running WIDTH-bit counter with live period/duty inputs.
// Optional output inversion is compiled in with the PWM_POLARITY_EN macro.
module pwm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wave_length,
    input  logic [WIDTH-1:0] high_time,
`ifdef PWM_POLARITY_EN
    input  logic             invert,
`endif
    output logic             out,
    output logic             last_cycle
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             last_q;
    logic             last_d;
    logic             wrap;
    logic             out_rst_val;

    // The >= test also catches a wave_length lowered below cnt, so the
    // counter wraps at once instead of running on to 2^WIDTH.
    assign wrap = (cnt_q >= wave_length);

`ifdef PWM_POLARITY_EN
    assign out_rst_val = invert;
`else
    assign out_rst_val = 1'b0;
`endif

    // Next-state: counter advance/wrap and the registered output values.
    always_comb begin
        cnt_d  = cnt_q + WIDTH'(1);
        out_d  = (cnt_q < high_time);
        last_d = wrap;
        if (wrap) begin
            cnt_d = '0;
        end
`ifdef PWM_POLARITY_EN
        out_d = out_d ^ invert;
`endif
    end

    // State registers; reset abandons any partial period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= out_rst_val;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            last_q <= last_d;
        end
    end

    assign out        = out_q;
    assign last_cycle = last_q;

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: per-scenario 18-cycle waveform tables plus
// sequences for a mid-run wave_length drop and an asynchronous reset.
module tb_pwm;

    logic       clk;
    logic       rst;
    logic [3:0] wave_length;
    logic [3:0] high_time;
    logic       out;
    logic       last_cycle;

    logic [1:0] wl2;
    logic [1:0] ht2;
    logic       out2;
    logic       last2;

    int checks;
    int errors;

    pwm #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wave_length(wave_length),
        .high_time  (high_time),
        .out        (out),
        .last_cycle (last_cycle)
    );

    pwm #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .wave_length(wl2),
        .high_time  (ht2),
        .out        (out2),
        .last_cycle (last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  wl;
        logic [3:0]  ht;
        logic [17:0] out_pat;
        logic [17:0] last_pat;
    } vec_t;

    vec_t vecs[7];

    // Cycle c (1..18 after reset release) is bit 18-c of each pattern.
    localparam logic [17:0] OUT2_PAT  = 18'b100010001000100010;
    localparam logic [17:0] LAST2_PAT = 18'b000100010001000100;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset out", out, 1'b0);
        chk("reset last", last_cycle, 1'b0);
        chk("reset out2", out2, 1'b0);
        chk("reset last2", last2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input string name, input logic eo, input logic el);
        @(posedge clk);
        @(negedge clk);
        chk({name, " out"}, out, eo);
        chk({name, " last"}, last_cycle, el);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        wave_length = 4'd8;
        high_time   = 4'd2;
        wl2         = 2'd3;
        ht2         = 2'd1;
        #1 rst      = 1'b1;

        vecs[0] = '{"wl8_ht2",  4'd8,  4'd2,
                    18'b110000000110000000, 18'b000000001000000001};
        vecs[1] = '{"wl8_ht0",  4'd8,  4'd0,
                    18'b000000000000000000, 18'b000000001000000001};
        vecs[2] = '{"wl8_ht9",  4'd8,  4'd9,
                    18'b111111111111111111, 18'b000000001000000001};
        vecs[3] = '{"wl0_ht0",  4'd0,  4'd0,
                    18'b000000000000000000, 18'b111111111111111111};
        vecs[4] = '{"wl0_ht1",  4'd0,  4'd1,
                    18'b111111111111111111, 18'b111111111111111111};
        vecs[5] = '{"wl3_ht3",  4'd3,  4'd3,
                    18'b111011101110111011, 18'b000100010001000100};
        vecs[6] = '{"wl15_ht8", 4'd15, 4'd8,
                    18'b111111110000000011, 18'b000000000000000100};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            wave_length = vecs[v].wl;
            high_time   = vecs[v].ht;
            for (int c = 1; c <= 18; c++) begin
                step(vecs[v].name, vecs[v].out_pat[18-c],
                     vecs[v].last_pat[18-c]);
                chk("w2 out", out2, OUT2_PAT[18-c]);
                chk("w2 last", last2, LAST2_PAT[18-c]);
            end
        end

        // wave_length drops from 8 to 2 while cnt = 6.
        do_reset();
        wave_length = 4'd8;
        high_time   = 4'd2;
        step("shrink e1", 1'b1, 1'b0);
        step("shrink e2", 1'b1, 1'b0);
        for (int c = 3; c <= 6; c++) begin
            step("shrink pre", 1'b0, 1'b0);
        end
        wave_length = 4'd2;
        step("shrink wrap", 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            step("shrink p0", 1'b1, 1'b0);
            step("shrink p1", 1'b1, 1'b0);
            step("shrink p2", 1'b0, 1'b1);
        end

        // Asynchronous reset mid-period, then restart from cnt = 0.
        do_reset();
        wave_length = 4'd8;
        high_time   = 4'd9;
        for (int c = 1; c <= 5; c++) begin
            step("pre rst", 1'b1, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        chk("async out", out, 1'b0);
        chk("async last", last_cycle, 1'b0);
        @(negedge clk);
        chk("held out", out, 1'b0);
        chk("held last", last_cycle, 1'b0);
        rst       = 1'b0;
        high_time = 4'd2;
        step("restart c1", 1'b1, 1'b0);
        step("restart c2", 1'b1, 1'b0);
        for (int c = 3; c <= 8; c++) begin
            step("restart lo", 1'b0, 1'b0);
        end
        step("restart c9", 1'b0, 1'b1);
        step("restart c10", 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
